// File: rtl/risc_pkg.sv
// Shared RISC pipeline definitions: control-transfer kinds and ALU op codes.
package risc_pkg;

    // Control-transfer kind carried on br_type; codes 9-15 are reserved and act as NONE.
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    // ALU operations selected by EX decode.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    // True for the two unconditional jumps that link pc+4 into rd.
    function automatic logic is_link(input logic [3:0] br_type);
        return (br_type == BR_JAL) || (br_type == BR_JALR);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution from the ALU result and EX operands.
module branch_resolve
    import risc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]      br_type,
    input  logic            alu_zero,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    // BLT/BLTU see slt/sltu in alu_out, so "less than" shows up as a non-zero result.
    always_comb begin
        taken  = 1'b0;
        target = pc + imm;
        case (br_type)
            BR_BEQ:  taken = alu_zero;
            BR_BNE:  taken = ~alu_zero;
            BR_BLT:  taken = ~alu_zero;
            BR_BGE:  taken = alu_zero;
            BR_BLTU: taken = ~alu_zero;
            BR_BGEU: taken = alu_zero;
            BR_JAL:  taken = 1'b1;
            BR_JALR: begin
                taken  = 1'b1;
                target = alu_out & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, one-cycle redirect and
// single wrong-path squash after a taken control transfer.
module ex_mem_stage
    import risc_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SHADOW_KILL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    input  logic [3:0]      br_type,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic [2:0]      funct3,
    output logic            m_valid,
    output logic [XLEN-1:0] m_result,
    output logic [XLEN-1:0] m_store_data,
    output logic [4:0]      m_rd,
    output logic            m_reg_write,
    output logic            m_mem_read,
    output logic            m_mem_write,
    output logic            m_mem_to_reg,
    output logic [2:0]      m_funct3,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misaligned
);

    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_accept;
    logic            w_redirect;
    logic            w_misaligned;
    logic [XLEN-1:0] w_result;

    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_store_data;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_mem_to_reg;
    logic [2:0]      r_funct3;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_misaligned;
    logic            r_kill;

    branch_resolve #(.XLEN(XLEN)) u_branch_resolve (
        .br_type  (br_type),
        .alu_zero (alu_zero),
        .alu_out  (alu_out),
        .pc       (pc),
        .imm      (imm),
        .taken    (w_taken),
        .target   (w_target)
    );

    // Decode the accepted-taken case and the value written into m_result.
    always_comb begin
        w_accept     = in_valid & ~stall & ~flush & ~r_kill;
        w_redirect   = w_accept & w_taken;
        w_misaligned = (w_target[1:0] != 2'b00);
        w_result     = is_link(br_type) ? (pc + XLEN'(4)) : alu_out;
    end

    // Pipeline register, kill flag and redirect pulse; flush > stall > kill > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid          <= 1'b0;
            r_result         <= '0;
            r_store_data     <= '0;
            r_rd             <= '0;
            r_reg_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_funct3         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_misaligned     <= 1'b0;
            r_kill           <= 1'b0;
        end else if (flush || (!stall && r_kill && in_valid)) begin
            r_valid          <= 1'b0;
            r_result         <= '0;
            r_store_data     <= '0;
            r_rd             <= '0;
            r_reg_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_funct3         <= '0;
            r_redirect_valid <= 1'b0;
            r_misaligned     <= 1'b0;
            r_kill           <= 1'b0;
        end else if (stall) begin
            r_redirect_valid <= 1'b0;
            r_misaligned     <= 1'b0;
        end else begin
            r_valid          <= in_valid;
            r_result         <= w_result;
            r_store_data     <= rs2_data;
            r_rd             <= rd;
            r_reg_write      <= reg_write & ~(w_redirect & w_misaligned);
            r_mem_read       <= mem_read;
            r_mem_write      <= mem_write;
            r_mem_to_reg     <= mem_to_reg;
            r_funct3         <= funct3;
            r_redirect_valid <= w_redirect;
            r_misaligned     <= w_redirect & w_misaligned;
            if (w_redirect) begin
                r_redirect_pc <= w_target;
                r_kill        <= (SHADOW_KILL != 0);
            end
        end
    end

    assign m_valid        = r_valid;
    assign m_result       = r_result;
    assign m_store_data   = r_store_data;
    assign m_rd           = r_rd;
    assign m_reg_write    = r_reg_write;
    assign m_mem_read     = r_mem_read;
    assign m_mem_write    = r_mem_write;
    assign m_mem_to_reg   = r_mem_to_reg;
    assign m_funct3       = r_funct3;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign misaligned     = r_misaligned;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: each task drives one scenario and checks
// hand-computed values one clock after the inputs are applied.
module tb_ex_mem_stage;
    import risc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [3:0]  br_type;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  funct3;
    logic        m_valid;
    logic [31:0] m_result;
    logic [31:0] m_store_data;
    logic [4:0]  m_rd;
    logic        m_reg_write;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        m_mem_to_reg;
    logic [2:0]  m_funct3;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned;

    int unsigned n_tests;
    int unsigned n_failed;

    ex_mem_stage #(.XLEN(32), .SHADOW_KILL(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .alu_out        (alu_out),
        .alu_zero       (alu_zero),
        .br_type        (br_type),
        .pc             (pc),
        .imm            (imm),
        .rs2_data       (rs2_data),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .funct3         (funct3),
        .m_valid        (m_valid),
        .m_result       (m_result),
        .m_store_data   (m_store_data),
        .m_rd           (m_rd),
        .m_reg_write    (m_reg_write),
        .m_mem_read     (m_mem_read),
        .m_mem_write    (m_mem_write),
        .m_mem_to_reg   (m_mem_to_reg),
        .m_funct3       (m_funct3),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one EX instruction; store data is derived from alu_out so it is predictable.
    task automatic drive(input logic v, input logic [3:0] bt, input logic [31:0] pcv,
                         input logic [31:0] immv, input logic [31:0] alu, input logic z,
                         input logic [4:0] rdv, input logic rw);
        in_valid   = v;
        br_type    = bt;
        pc         = pcv;
        imm        = immv;
        alu_out    = alu;
        alu_zero   = z;
        rd         = rdv;
        reg_write  = rw;
        rs2_data   = alu ^ 32'hA5A5_0000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        funct3     = 3'd2;
        stall      = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, BR_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        #2;
        n_tests++;
        if ({m_valid, m_result, m_store_data, m_rd, m_reg_write, m_mem_read, m_mem_write,
             m_mem_to_reg, m_funct3, redirect_valid, redirect_pc, misaligned} !== '0) begin
            n_failed++;
            $display("FAIL reset_outputs: m_valid=%0b m_result=%h redirect_valid=%0b redirect_pc=%h required all zero",
                     m_valid, m_result, redirect_valid, redirect_pc);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_beq_kill();
        drive(1'b1, BR_BEQ, 32'h100, 32'h20, 32'h0, 1'b1, 5'd0, 1'b0);
        step();
        n_tests++;
        if ({redirect_valid, redirect_pc, misaligned, m_valid} !== {1'b1, 32'h120, 1'b0, 1'b1}) begin
            n_failed++;
            $display("FAIL beq_redirect: rv=%0b pc=%h mis=%0b mv=%0b required rv=1 pc=00000120 mis=0 mv=1",
                     redirect_valid, redirect_pc, misaligned, m_valid);
        end
        drive(1'b1, BR_NONE, 32'h104, 32'h0, 32'h55, 1'b0, 5'd3, 1'b1);
        step();
        n_tests++;
        if ({m_valid, m_reg_write, redirect_valid, redirect_pc} !== {1'b0, 1'b0, 1'b0, 32'h120}) begin
            n_failed++;
            $display("FAIL beq_shadow_killed: mv=%0b rw=%0b rv=%0b pc=%h required mv=0 rw=0 rv=0 pc=00000120",
                     m_valid, m_reg_write, redirect_valid, redirect_pc);
        end
        step();
        n_tests++;
        if ({m_valid, m_result, m_store_data, m_rd, m_reg_write, m_funct3}
            !== {1'b1, 32'h55, 32'hA5A5_0055, 5'd3, 1'b1, 3'd2}) begin
            n_failed++;
            $display("FAIL beq_after_kill: mv=%0b res=%h sd=%h rd=%0d rw=%0b f3=%0d required 1 00000055 a5a50055 3 1 2",
                     m_valid, m_result, m_store_data, m_rd, m_reg_write, m_funct3);
        end
    endtask

    task automatic test_bltu();
        drive(1'b1, BR_BLTU, 32'h200, 32'h10, 32'h1, 1'b0, 5'd0, 1'b0);
        step();
        n_tests++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h210}) begin
            n_failed++;
            $display("FAIL bltu_taken: rv=%0b pc=%h required rv=1 pc=00000210", redirect_valid, redirect_pc);
        end
        drive(1'b1, BR_NONE, 32'h204, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0);
        step();
        drive(1'b1, BR_BLTU, 32'h300, 32'h10, 32'h0, 1'b1, 5'd0, 1'b0);
        step();
        n_tests++;
        if ({redirect_valid, m_valid, m_result, redirect_pc} !== {1'b0, 1'b1, 32'h0, 32'h210}) begin
            n_failed++;
            $display("FAIL bltu_not_taken: rv=%0b mv=%0b res=%h pc=%h required rv=0 mv=1 res=0 pc=00000210",
                     redirect_valid, m_valid, m_result, redirect_pc);
        end
        drive(1'b1, 4'd12, 32'h304, 32'h40, 32'h7, 1'b0, 5'd1, 1'b1);
        step();
        n_tests++;
        if ({redirect_valid, m_valid, m_result} !== {1'b0, 1'b1, 32'h7}) begin
            n_failed++;
            $display("FAIL reserved_code: rv=%0b mv=%0b res=%h required rv=0 mv=1 res=00000007",
                     redirect_valid, m_valid, m_result);
        end
    endtask

    task automatic test_jalr();
        drive(1'b1, BR_JALR, 32'h40, 32'h0, 32'h2003, 1'b0, 5'd1, 1'b1);
        step();
        n_tests++;
        if ({redirect_valid, redirect_pc, m_result, misaligned, m_reg_write, m_valid}
            !== {1'b1, 32'h2002, 32'h44, 1'b1, 1'b0, 1'b1}) begin
            n_failed++;
            $display("FAIL jalr_misaligned: rv=%0b pc=%h res=%h mis=%0b rw=%0b mv=%0b required 1 00002002 00000044 1 0 1",
                     redirect_valid, redirect_pc, m_result, misaligned, m_reg_write, m_valid);
        end
        drive(1'b1, BR_NONE, 32'h44, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        step();
        n_tests++;
        if ({misaligned, redirect_valid, m_valid} !== 3'b000) begin
            n_failed++;
            $display("FAIL jalr_pulse_end: mis=%0b rv=%0b mv=%0b required 0 0 0", misaligned, redirect_valid, m_valid);
        end
    endtask

    task automatic test_stall_redirect();
        drive(1'b1, BR_BNE, 32'h300, 32'h8, 32'h11, 1'b0, 5'd4, 1'b0);
        step();
        n_tests++;
        if ({redirect_valid, redirect_pc, m_result} !== {1'b1, 32'h308, 32'h11}) begin
            n_failed++;
            $display("FAIL bne_redirect: rv=%0b pc=%h res=%h required 1 00000308 00000011",
                     redirect_valid, redirect_pc, m_result);
        end
        drive(1'b1, BR_NONE, 32'h304, 32'h0, 32'h77, 1'b0, 5'd5, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({redirect_valid, m_valid, m_result, m_rd, redirect_pc} !== {1'b0, 1'b1, 32'h11, 5'd4, 32'h308}) begin
                n_failed++;
                $display("FAIL stall_hold[%0d]: rv=%0b mv=%0b res=%h rd=%0d pc=%h required 0 1 00000011 4 00000308",
                         i, redirect_valid, m_valid, m_result, m_rd, redirect_pc);
            end
        end
        stall = 1'b0;
        step();
        n_tests++;
        if ({m_valid, redirect_valid} !== 2'b00) begin
            n_failed++;
            $display("FAIL stall_then_kill: mv=%0b rv=%0b required 0 0", m_valid, redirect_valid);
        end
        drive(1'b1, BR_NONE, 32'h308, 32'h0, 32'h99, 1'b0, 5'd6, 1'b1);
        step();
        n_tests++;
        if ({m_valid, m_result, m_rd, m_reg_write} !== {1'b1, 32'h99, 5'd6, 1'b1}) begin
            n_failed++;
            $display("FAIL stall_resume: mv=%0b res=%h rd=%0d rw=%0b required 1 00000099 6 1",
                     m_valid, m_result, m_rd, m_reg_write);
        end
    endtask

    task automatic test_flush_wrap();
        drive(1'b1, BR_NONE, 32'h400, 32'h0, 32'h1234, 1'b0, 5'd7, 1'b1);
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        mem_to_reg = 1'b1;
        stall      = 1'b1;
        flush      = 1'b1;
        step();
        n_tests++;
        if ({m_valid, m_reg_write, m_mem_read, m_mem_write, m_mem_to_reg, m_result, m_rd, m_funct3, redirect_valid} !== '0) begin
            n_failed++;
            $display("FAIL flush_over_stall: mv=%0b rw=%0b mr=%0b mw=%0b m2r=%0b res=%h rd=%0d required all 0",
                     m_valid, m_reg_write, m_mem_read, m_mem_write, m_mem_to_reg, m_result, m_rd);
        end
        drive(1'b1, BR_BEQ, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1, 5'd0, 1'b0);
        step();
        n_tests++;
        if ({redirect_valid, redirect_pc, misaligned} !== {1'b1, 32'h0000_0010, 1'b0}) begin
            n_failed++;
            $display("FAIL target_wrap: rv=%0b pc=%h mis=%0b required 1 00000010 0", redirect_valid, redirect_pc, misaligned);
        end
        drive(1'b0, BR_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        flush = 1'b1;
        step();
        drive(1'b1, BR_NONE, 32'h10, 32'h0, 32'h66, 1'b0, 5'd8, 1'b1);
        step();
        n_tests++;
        if ({m_valid, m_result} !== {1'b1, 32'h66}) begin
            n_failed++;
            $display("FAIL flush_clears_kill: mv=%0b res=%h required 1 00000066", m_valid, m_result);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, BR_JAL, 32'h500, 32'h40, 32'hDEAD, 1'b0, 5'd9, 1'b1);
        step();
        n_tests++;
        if ({redirect_valid, redirect_pc, m_result} !== {1'b1, 32'h540, 32'h504}) begin
            n_failed++;
            $display("FAIL jal_redirect: rv=%0b pc=%h res=%h required 1 00000540 00000504",
                     redirect_valid, redirect_pc, m_result);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, m_result, m_store_data, m_rd, m_reg_write, m_funct3,
             redirect_valid, redirect_pc, misaligned} !== '0) begin
            n_failed++;
            $display("FAIL async_reset: mv=%0b res=%h rv=%0b pc=%h required all 0",
                     m_valid, m_result, redirect_valid, redirect_pc);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, BR_NONE, 32'h600, 32'h0, 32'h33, 1'b0, 5'd10, 1'b1);
        step();
        n_tests++;
        if ({m_valid, m_result, m_rd, redirect_valid} !== {1'b1, 32'h33, 5'd10, 1'b0}) begin
            n_failed++;
            $display("FAIL post_reset_latch: mv=%0b res=%h rd=%0d rv=%0b required 1 00000033 10 0",
                     m_valid, m_result, m_rd, redirect_valid);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        test_reset();
        test_beq_kill();
        test_bltu();
        test_jalr();
        test_stall_redirect();
        test_flush_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Sits directly downstream of the ALU in the 5-stage RISC pipeline.
- Consumes the ALU result, the ALU zero flag and the EX-stage control bundle, and resolves branches and jumps from that result.
- Latches everything into the EX/MEM pipeline register and emits a one-cycle PC redirect.
- Squashes the wrong-path instruction that follows a taken control transfer.

Parameters:
- XLEN, 32, datapath width.
- SHADOW_KILL, 1, 1 = squash the instruction in EX during the redirect cycle; 0 = rely on the external flush only.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset asynchronous, active-low
- stall  in  1  hold the EX/MEM register (memory busy)
- flush  in  1  load a bubble (trap or external squash)
- in_valid  in  1  EX holds a real instruction
- alu_out  in  XLEN  ALU result
- alu_zero  in  1  ALU zero flag
- br_type  in  4  control-transfer kind (package encoding)
- pc  in  XLEN  PC of the EX instruction
- imm  in  XLEN  sign-extended immediate
- rs2_data  in  XLEN  store data
- rd  in  5  destination register
- reg_write, mem_read, mem_write, mem_to_reg  in  1 each  control bits
- funct3  in  3  memory access size/sign
- m_valid  out  1  EX/MEM entry valid
- m_result  out  XLEN  alu_out, or pc+4 for JAL/JALR
- m_store_data  out  XLEN  latched rs2_data
- m_rd  out  5  latched rd
- m_reg_write, m_mem_read, m_mem_write, m_mem_to_reg  out  1 each  latched control bits
- m_funct3  out  3  latched funct3
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  XLEN  redirect target
- misaligned  out  1  the taken target had target[1:0] != 0

Behaviour:
- Reset (async, rst_n low): every output is 0 and the kill flag is cleared. Asserting reset mid-operation discards the pending redirect and kill immediately.
- Taken condition, combinational on EX inputs:
  - BEQ: alu_zero. BNE: !alu_zero.
  - BLT and BLTU (ALU computes slt/sltu): !alu_zero.
  - BGE and BGEU: alu_zero.
  - JAL and JALR: always taken. NONE and reserved codes: never taken.
- Target:
  - Conditional branches and JAL: pc+imm, modulo 2^XLEN (wraps).
  - JALR: alu_out & ~1.
- accept = in_valid & !stall & !flush & !kill.
- On each rising edge, in priority order:
  - flush: load a bubble. m_valid and all m_* control bits go to 0, data fields to 0, kill clears, redirect_valid = 0. Flush wins over stall.
  - stall: all m_* hold, redirect_valid = 0, kill holds.
  - kill set and in_valid: load a bubble and clear kill. This consumes exactly one wrong-path instruction.
  - otherwise: load the EX fields, with m_valid = in_valid.
- When an accepted instruction is taken:
  - redirect_valid = 1 and redirect_pc = target, for exactly one cycle; redirect_valid returns to 0 the next cycle even if stall rises.
  - kill is set if SHADOW_KILL = 1.
  - misaligned = (target[1:0] != 0). When set, the redirect is still issued, but m_reg_write is forced to 0.
- redirect_pc holds its last value when redirect_valid = 0.
- JAL/JALR write pc+4 to m_result; alu_out is discarded.
- Latency: 1 cycle from EX inputs to every output. No combinational path from inputs to outputs.

Decomposition:
- Shared package risc_pkg holds:
  - BR_NONE=0, BR_BEQ=1, BR_BNE=2, BR_BLT=3, BR_BGE=4, BR_BLTU=5, BR_BGEU=6, BR_JAL=7, BR_JALR=8; codes 9-15 are reserved and treated as NONE.
  - The ALUop constants used by EX decode.
- One combinational sub-module, branch_resolve: inputs br_type, alu_zero, alu_out, pc, imm; outputs taken, target. The register, kill flag and priority logic stay in ex_mem_stage.

Test Plan:
1. BEQ at pc=0x100, imm=0x20, alu_zero=1 -> next cycle redirect_valid=1, redirect_pc=0x120; the following in_valid instruction is captured with m_valid=0.
2. BLTU with alu_out=1 (alu_zero=0) -> taken. Same inputs with alu_out=0 -> no redirect, m_valid=1, m_result=0.
3. JALR with alu_out=0x2003, pc=0x40 -> redirect_pc=0x2002, m_result=0x44, misaligned=1, m_reg_write=0.
4. Taken BNE, then stall=1 for 3 cycles -> redirect_valid high for exactly 1 cycle, m_* held; after release the next instruction is killed once, and the one after is latched normally.
5. flush and stall both high with valid ADD input -> m_valid=0 and all control bits 0. Branch pc=0xFFFFFFF0 with imm=0x20 -> redirect_pc=0x00000010.
6. rst_n low for 1 cycle mid-redirect, asynchronously -> all outputs 0 immediately and kill cleared; the first instruction after reset is latched normally.
